draw_sprite_layer: RTL and testbench

Parametrised sprite overlay stage for the VGA pixel pipeline. It supersedes the fixed-position menu image drawer. Position is set at runtime, the image size and ROM latency are parameters, and the block adds a colour-key enable, frame-synchronous position/mode update, blink, highlight and hide modes. It sits between a timing/background stage and the next overlay stage, and drives a synchronous image ROM.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/delay_line.sv | 29 ++
 rtl/draw_sprite_layer.sv | 182 ++++++++++++++++++
 tb/tb_draw_sprite_layer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: timing widths, colour type, overlay modes
// and the pixel/control word carried alongside the image ROM lookup.
package vga_pkg;
    localparam int HC_W  = 11;
    localparam int VC_W  = 10;
    localparam int RGB_W = 12;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_HILITE = 2'b10,
        MODE_HIDDEN = 2'b11
    } mode_t;

    // Everything about one pixel that must stay aligned with its ROM word.
    typedef struct packed {
        logic [HC_W-1:0] hcount;
        logic [VC_W-1:0] vcount;
        logic            hblnk;
        logic            vblnk;
        rgb_t            rgb;
        logic            show;
        logic            key_en;
        logic            hilite;
    } pix_ctl_t;

    function automatic logic [3:0] sat_add4(input logic [3:0] c, input logic [4:0] a);
        logic [5:0] s;
        s = {2'b00, c} + {1'b0, a};
        return (s > 6'd15) ? 4'hF : s[3:0];
    endfunction
endpackage

// File: rtl/delay_line.sv
// Fixed-depth register pipeline with synchronous clear, used to keep pixel
// timing and control aligned with the image ROM data.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] r_q;
        logic [WIDTH-1:0] w_d;

        if (gi == 0) begin : g_first
            assign w_d = i_data;
        end else begin : g_next
            assign w_d = g_stage[gi-1].r_q;
        end

        always_ff @(posedge clk) begin
            if (rst) r_q <= '0;
            else     r_q <= w_d;
        end
    end

    assign o_data = g_stage[DEPTH-1].r_q;
endmodule

// File: rtl/draw_sprite_layer.sv
// Sprite overlay stage: runtime-positioned image from a synchronous ROM with
// colour key, frame-synchronous updates and blink/highlight/hide modes.
module draw_sprite_layer
    import vga_pkg::*;
#(
    parameter int         IMG_W_LOG2   = 9,
    parameter int         IMG_H_LOG2   = 6,
    parameter int         ROM_LAT      = 1,
    parameter logic [11:0] KEY_COLOR   = 12'hFFF,
    parameter int         XPOS_INIT    = 256,
    parameter int         YPOS_INIT    = 320,
    parameter int         BLINK_FRAMES = 30,
    parameter int         HILITE_ADD   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [10:0]                      hcount_in,
    input  logic [9:0]                       vcount_in,
    input  logic                             hblnk_in,
    input  logic                             vblnk_in,
    input  logic [11:0]                      rgb_in,
    input  logic [10:0]                      xpos,
    input  logic [9:0]                       ypos,
    input  logic [1:0]                       mode,
    input  logic                             key_en,
    output logic [IMG_W_LOG2+IMG_H_LOG2-1:0] pixel_addr,
    input  logic [11:0]                      rgb_pixel,
    output logic [10:0]                      hcount_out,
    output logic [9:0]                       vcount_out,
    output logic                             hblnk_out,
    output logic                             vblnk_out,
    output logic [11:0]                      rgb_out
);
    localparam int          AW      = IMG_W_LOG2 + IMG_H_LOG2;
    localparam logic [11:0] IMG_W   = 12'(1 << IMG_W_LOG2);
    localparam logic [11:0] IMG_H   = 12'(1 << IMG_H_LOG2);
    localparam int          BC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);
    localparam logic [4:0]  HL_ADD  = 5'(HILITE_ADD);
    localparam int          CTL_W   = $bits(pix_ctl_t);

    logic            r_vblnk_prev;
    logic [10:0]     r_xpos;
    logic [9:0]      r_ypos;
    mode_t           r_mode;
    logic            r_key_en;
    logic [BC_W-1:0] r_blink_cnt;
    logic            r_visible;
    logic [AW-1:0]   r_pixel_addr;

    logic [10:0] r_hcount_out;
    logic [9:0]  r_vcount_out;
    logic        r_hblnk_out;
    logic        r_vblnk_out;
    rgb_t        r_rgb_out;

    logic        w_frame_start;
    logic [11:0] w_x_lo, w_x_hi, w_y_lo, w_y_hi, w_h_ext, w_v_ext;
    logic        w_inside;
    logic [10:0] w_dx;
    logic [9:0]  w_dy;
    pix_ctl_t    w_s0, w_s1, w_al;
    rgb_t        w_hi_pix;
    rgb_t        w_rgb_mix;

    assign w_frame_start = vblnk_in & ~r_vblnk_prev;

    // Latched position/mode and blink state change only at frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk_prev <= 1'b0;
            r_xpos       <= 11'(XPOS_INIT);
            r_ypos       <= 10'(YPOS_INIT);
            r_mode       <= MODE_NORMAL;
            r_key_en     <= 1'b0;
            r_blink_cnt  <= '0;
            r_visible    <= 1'b1;
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (w_frame_start) begin
                r_xpos   <= xpos;
                r_ypos   <= ypos;
                r_mode   <= mode_t'(mode);
                r_key_en <= key_en;
                if (r_mode == MODE_BLINK) begin
                    if (r_blink_cnt == BC_LAST) begin
                        r_blink_cnt <= '0;
                        r_visible   <= ~r_visible;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + BC_W'(1);
                    end
                end else begin
                    r_blink_cnt <= '0;
                    r_visible   <= 1'b1;
                end
            end
        end
    end

    // 12-bit bounds so a sprite hanging off the right/bottom never wraps.
    assign w_h_ext = {1'b0, hcount_in};
    assign w_v_ext = {2'b00, vcount_in};
    assign w_x_lo  = {1'b0, r_xpos};
    assign w_y_lo  = {2'b00, r_ypos};
    assign w_x_hi  = w_x_lo + IMG_W;
    assign w_y_hi  = w_y_lo + IMG_H;

    assign w_inside = !hblnk_in && !vblnk_in
                   && (w_h_ext >= w_x_lo) && (w_h_ext < w_x_hi)
                   && (w_v_ext >= w_y_lo) && (w_v_ext < w_y_hi);

    assign w_dx = hcount_in - r_xpos;
    assign w_dy = vcount_in - r_ypos;

    always_ff @(posedge clk) begin
        if (rst)           r_pixel_addr <= '0;
        else if (w_inside) r_pixel_addr <= {w_dy[IMG_H_LOG2-1:0], w_dx[IMG_W_LOG2-1:0]};
        else               r_pixel_addr <= '0;
    end

    assign pixel_addr = r_pixel_addr;

    // Mode decisions are frozen per pixel so a frame-start never affects pixels in flight.
    always_comb begin
        w_s0        = '0;
        w_s0.hcount = hcount_in;
        w_s0.vcount = vcount_in;
        w_s0.hblnk  = hblnk_in;
        w_s0.vblnk  = vblnk_in;
        w_s0.rgb    = rgb_in;
        w_s0.show   = w_inside && (r_mode != MODE_HIDDEN)
                   && !((r_mode == MODE_BLINK) && !r_visible);
        w_s0.key_en = r_key_en;
        w_s0.hilite = (r_mode == MODE_HILITE);
    end

    delay_line #(.WIDTH(CTL_W), .DEPTH(1)) u_stage1 (
        .clk    (clk),
        .rst    (rst),
        .i_data (w_s0),
        .o_data (w_s1)
    );

    delay_line #(.WIDTH(CTL_W), .DEPTH(ROM_LAT)) u_rom_align (
        .clk    (clk),
        .rst    (rst),
        .i_data (w_s1),
        .o_data (w_al)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_hilite
        assign w_hi_pix[gi*4 +: 4] = sat_add4(rgb_pixel[gi*4 +: 4], HL_ADD);
    end

    always_comb begin
        w_rgb_mix = w_al.rgb;
        if (w_al.show && !(w_al.key_en && (rgb_pixel == KEY_COLOR)))
            w_rgb_mix = w_al.hilite ? w_hi_pix : rgb_pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount_out <= '0;
            r_vcount_out <= '0;
            r_hblnk_out  <= 1'b0;
            r_vblnk_out  <= 1'b0;
            r_rgb_out    <= '0;
        end else begin
            r_hcount_out <= w_al.hcount;
            r_vcount_out <= w_al.vcount;
            r_hblnk_out  <= w_al.hblnk;
            r_vblnk_out  <= w_al.vblnk;
            r_rgb_out    <= w_rgb_mix;
        end
    end

    assign hcount_out = r_hcount_out;
    assign vcount_out = r_vcount_out;
    assign hblnk_out  = r_hblnk_out;
    assign vblnk_out  = r_vblnk_out;
    assign rgb_out    = r_rgb_out;
endmodule

// File: tb/tb_draw_sprite_layer.sv
// Scoreboard bench for draw_sprite_layer: ROM_LAT=1/BLINK_FRAMES=2 instance
// plus a ROM_LAT=3 instance sharing the same stimulus.
module tb_draw_sprite_layer;
    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, xpos;
    logic [9:0]  vcount_in, ypos;
    logic        hblnk_in, vblnk_in, key_en;
    logic [11:0] rgb_in;
    logic [1:0]  mode;

    logic [14:0] addr1, addr3;
    logic [11:0] pix1, pix3;
    logic [10:0] h1, h3;
    logic [9:0]  v1, v3;
    logic        hb1, hb3, vb1, vb3;
    logic [11:0] rgb1, rgb3;

    draw_sprite_layer #(.ROM_LAT(1), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .xpos(xpos), .ypos(ypos), .mode(mode), .key_en(key_en),
        .pixel_addr(addr1), .rgb_pixel(pix1),
        .hcount_out(h1), .vcount_out(v1), .hblnk_out(hb1), .vblnk_out(vb1),
        .rgb_out(rgb1)
    );

    draw_sprite_layer #(.ROM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .xpos(xpos), .ypos(ypos), .mode(mode), .key_en(key_en),
        .pixel_addr(addr3), .rgb_pixel(pix3),
        .hcount_out(h3), .vcount_out(v3), .hblnk_out(hb3), .vblnk_out(vb3),
        .rgb_out(rgb3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: address 0 is programmable, every other word is addr ^ 0xC3C.
    logic [11:0] rom0;
    function automatic logic [11:0] rom_f(input logic [14:0] a);
        return (a == 15'd0) ? rom0 : (12'(a) ^ 12'hC3C);
    endfunction

    logic [11:0] rom1_q, rom3_a, rom3_b, rom3_c;
    always @(posedge clk) begin
        rom1_q <= rom_f(addr1);
        rom3_a <= rom_f(addr3);
        rom3_b <= rom3_a;
        rom3_c <= rom3_b;
    end
    assign pix1 = rom1_q;
    assign pix3 = rom3_c;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    typedef struct {
        int          due;
        logic [10:0] h;
        logic [9:0]  v;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        string       name;
    } exp_t;

    typedef struct {
        int          due;
        logic [14:0] addr;
        string       name;
    } aexp_t;

    exp_t  q1[$], q3[$];
    aexp_t qa1[$], qa3[$];

    always @(negedge clk) begin : monitor
        exp_t  e;
        aexp_t a;
        while (q1.size() > 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            chk({e.name, "/rgb_l1"}, 32'(rgb1), 32'(e.rgb));
            chk({e.name, "/timing_l1"}, 32'({h1, v1, hb1, vb1}), 32'({e.h, e.v, e.hb, e.vb}));
            $display("out  lat1 %-16s h=%0d v=%0d rgb=%h", e.name, h1, v1, rgb1);
        end
        while (q3.size() > 0 && q3[0].due <= cyc) begin
            e = q3.pop_front();
            chk({e.name, "/rgb_l3"}, 32'(rgb3), 32'(e.rgb));
            chk({e.name, "/timing_l3"}, 32'({h3, v3, hb3, vb3}), 32'({e.h, e.v, e.hb, e.vb}));
            $display("out  lat3 %-16s h=%0d v=%0d rgb=%h", e.name, h3, v3, rgb3);
        end
        while (qa1.size() > 0 && qa1[0].due <= cyc) begin
            a = qa1.pop_front();
            chk({a.name, "/addr_l1"}, 32'(addr1), 32'(a.addr));
            $display("addr lat1 %-16s addr=%h", a.name, addr1);
        end
        while (qa3.size() > 0 && qa3[0].due <= cyc) begin
            a = qa3.pop_front();
            chk({a.name, "/addr_l3"}, 32'(addr3), 32'(a.addr));
            $display("addr lat3 %-16s addr=%h", a.name, addr3);
        end
    end

    task automatic drive(input int h, input int v, input logic hb, input logic vb, input logic [11:0] rgb);
        @(posedge clk);
        #1;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 1'b1, 1'b0, 12'h000);
    endtask

    task automatic frame_start();
        drive(0, 0, 1'b1, 1'b1, 12'h000);
        idle(2);
    endtask

    // Expectation for the pixel currently on the inputs.
    task automatic exp_out(input int lat, input logic [11:0] rgb, input string name);
        exp_t e;
        e.due  = cyc + lat + 2;
        e.h    = hcount_in;
        e.v    = vcount_in;
        e.hb   = hblnk_in;
        e.vb   = vblnk_in;
        e.rgb  = rgb;
        e.name = name;
        if (lat == 1) q1.push_back(e);
        else          q3.push_back(e);
    endtask

    task automatic exp_addr(input int lat, input logic [14:0] addr, input string name);
        aexp_t a;
        a.due  = cyc + 1;
        a.addr = addr;
        a.name = name;
        if (lat == 1) qa1.push_back(a);
        else          qa3.push_back(a);
    endtask

    logic [11:0] bexp [8];

    initial begin
        rst = 1'b1;
        hcount_in = 11'd5; vcount_in = 10'd3; hblnk_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = 12'hABC; xpos = 11'd100; ypos = 10'd50; mode = 2'b00; key_en = 1'b0;
        rom0 = 12'h0A5;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_rgb_l1", 32'(rgb1), 32'h0);
        chk("reset_timing_l1", 32'({h1, v1, hb1, vb1}), 32'h0);
        chk("reset_addr_l1", 32'(addr1), 32'h0);
        chk("reset_rgb_l3", 32'(rgb3), 32'h0);
        chk("reset_timing_l3", 32'({h3, v3, hb3, vb3}), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);

        // Reset position (256,320); xpos/ypos inputs already differ but no frame start yet.
        drive(256, 320, 1'b0, 1'b0, 12'h123);
        exp_out(1, 12'h0A5, "origin"); exp_addr(1, 15'h0000, "origin");
        exp_out(3, 12'h0A5, "origin"); exp_addr(3, 15'h0000, "origin");
        drive(257, 321, 1'b0, 1'b0, 12'h124);
        exp_out(1, 12'hE3D, "diag"); exp_addr(1, 15'h0201, "diag");
        drive(255, 320, 1'b0, 1'b0, 12'h456);
        exp_out(1, 12'h456, "left_of"); exp_addr(1, 15'h0000, "left_of");
        drive(256, 320, 1'b1, 1'b0, 12'h457);
        exp_out(1, 12'h457, "hblank");
        idle(4);

        // Position update only after the vblank rise.
        drive(100, 50, 1'b0, 1'b0, 12'h111);
        exp_out(1, 12'h111, "pre_fs");
        idle(2);
        frame_start();
        drive(100, 50, 1'b0, 1'b0, 12'h222);
        exp_out(1, 12'h0A5, "new_origin"); exp_addr(1, 15'h0000, "new_origin");
        drive(611, 113, 1'b0, 1'b0, 12'h223);
        exp_out(1, 12'h3C3, "corner"); exp_addr(1, 15'h7FFF, "corner");
        drive(612, 50, 1'b0, 1'b0, 12'h333);
        exp_out(1, 12'h333, "right_edge"); exp_addr(1, 15'h0000, "right_edge");
        drive(100, 114, 1'b0, 1'b0, 12'h334);
        exp_out(1, 12'h334, "bottom_edge");
        drive(99, 50, 1'b0, 1'b0, 12'h335);
        exp_out(1, 12'h335, "left_edge");
        idle(4);

        // Colour key.
        rom0 = 12'hFFF; key_en = 1'b1;
        drive(100, 50, 1'b0, 1'b0, 12'h123);
        exp_out(1, 12'hFFF, "key_pending");
        idle(2);
        frame_start();
        drive(100, 50, 1'b0, 1'b0, 12'h123);
        exp_out(1, 12'h123, "key_on");
        drive(101, 50, 1'b0, 1'b0, 12'h124);
        exp_out(1, 12'hC3D, "key_on_other");
        idle(2);
        key_en = 1'b0;
        frame_start();
        drive(100, 50, 1'b0, 1'b0, 12'h123);
        exp_out(1, 12'hFFF, "key_off");
        idle(4);

        // Highlight and hidden.
        mode = 2'b10; rom0 = 12'h3DF;
        frame_start();
        drive(100, 50, 1'b0, 1'b0, 12'h123);
        exp_out(1, 12'h7FF, "hilite_sat");
        idle(3);
        rom0 = 12'h0A5;
        drive(100, 50, 1'b0, 1'b0, 12'h123);
        exp_out(1, 12'h4E9, "hilite_add");
        idle(3);
        mode = 2'b11;
        frame_start();
        drive(100, 50, 1'b0, 1'b0, 12'h5A5);
        exp_out(1, 12'h5A5, "hidden");
        idle(3);

        // Blink with two frames per half-period, then back to normal.
        bexp = '{12'h0A5, 12'h0A5, 12'h0F0, 12'h0F0, 12'h0A5, 12'h0A5, 12'h0F0, 12'h0A5};
        mode = 2'b01;
        for (int f = 0; f < 8; f++) begin
            if (f == 7) mode = 2'b00;
            frame_start();
            drive(100, 50, 1'b0, 1'b0, 12'h0F0);
            exp_out(1, bexp[f], $sformatf("blink_f%0d", f + 1));
            idle(3);
        end

        // Right-edge clip; blank edges through both latencies.
        xpos = 11'd700;
        frame_start();
        drive(699, 50, 1'b0, 1'b0, 12'h111);
        exp_out(1, 12'h111, "clip_before"); exp_out(3, 12'h111, "clip_before");
        drive(700, 50, 1'b0, 1'b0, 12'h112);
        exp_out(1, 12'h0A5, "clip_first"); exp_out(3, 12'h0A5, "clip_first");
        exp_addr(3, 15'h0000, "clip_first");
        drive(799, 50, 1'b0, 1'b0, 12'h113);
        exp_out(3, 12'hC5F, "clip_last"); exp_addr(3, 15'd99, "clip_last");
        drive(800, 50, 1'b1, 1'b0, 12'h114);
        exp_out(1, 12'h114, "clip_hblank"); exp_out(3, 12'h114, "clip_hblank");
        idle(2);
        xpos = 11'd1800;
        drive(0, 600, 1'b1, 1'b1, 12'h0AB);
        exp_out(1, 12'h0AB, "vblank_edge"); exp_out(3, 12'h0AB, "vblank_edge");
        idle(2);

        // Sprite end beyond 2047 must not wrap.
        drive(2000, 50, 1'b0, 1'b0, 12'h222);
        exp_out(1, 12'hCF4, "nowrap_in"); exp_addr(1, 15'd200, "nowrap_in");
        exp_out(3, 12'hCF4, "nowrap_in");
        drive(1799, 50, 1'b0, 1'b0, 12'h223);
        exp_out(1, 12'h223, "nowrap_left");
        drive(100, 50, 1'b0, 1'b0, 12'h224);
        exp_out(1, 12'h224, "nowrap_low");
        idle(10);

        chk("drain", 32'(q1.size() + q3.size() + qa1.size() + qa3.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
